// File: rtl/dds_pkg.sv
// Shared definitions for the DDS configuration path: word widths, the
// config word layout and the tdata packing used by every DDS-side block.
package dds_pkg;

    localparam int DDS_PINC_W  = 16;
    localparam int DDS_POFF_W  = 16;
    localparam int DDS_TDATA_W = 32;

    typedef struct packed {
        logic [DDS_POFF_W-1:0] poff;
        logic [DDS_PINC_W-1:0] pinc;
    } cfg_word_t;

    // Layout is {zero pad, poff, pinc}; pinc sits in the low bits.
    function automatic logic [DDS_TDATA_W-1:0] pack_cfg(input cfg_word_t w);
        return DDS_TDATA_W'({w.poff, w.pinc});
    endfunction

endpackage

// File: rtl/dds_cfg_bridge.sv
// Captures strobed pinc/poff updates and presents them to the DDS config
// channel as AXI-Stream beats through a two-slot buffer (latest-wins on stall).
module dds_cfg_bridge
    import dds_pkg::*;
#(
    parameter int PINC_W    = DDS_PINC_W,
    parameter int POFF_W    = DDS_POFF_W,
    parameter int TDATA_W   = DDS_TDATA_W,
    parameter int OVR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_cfg_valid,
    input  logic [PINC_W-1:0]    i_pinc,
    input  logic [POFF_W-1:0]    i_poff,
    input  logic                 i_flush,
    output logic [TDATA_W-1:0]   m_axis_config_tdata,
    output logic                 m_axis_config_tvalid,
    input  logic                 m_axis_config_tready,
    output logic                 o_cfg_done,
    output logic                 o_overrun,
    output logic [OVR_CNT_W-1:0] o_overrun_cnt,
    output logic                 o_busy
);

    generate
        if (TDATA_W < PINC_W + POFF_W) begin : g_width_check
            $error("dds_cfg_bridge: TDATA_W must be >= PINC_W + POFF_W");
        end
    endgenerate

    logic [TDATA_W-1:0] out_data;
    logic               out_valid;
    logic [TDATA_W-1:0] pend_data;
    logic               pend_valid;
    logic [TDATA_W-1:0] new_word;
    logic               fire;

    // Zero-extending cast pads the upper bits whatever the spare width is.
    assign new_word = TDATA_W'({i_poff, i_pinc});
    assign fire     = out_valid & m_axis_config_tready;

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, as the hardware does.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data      <= '0;
            out_valid     <= 1'b0;
            pend_data     <= '0;
            pend_valid    <= 1'b0;
            o_cfg_done    <= 1'b0;
            o_overrun     <= 1'b0;
            o_overrun_cnt <= '0;
        end else begin
            o_cfg_done <= fire;
            o_overrun  <= 1'b0;
            if (i_flush) begin
                pend_valid <= 1'b0;
                pend_data  <= '0;
                out_valid  <= i_cfg_valid;
                if (i_cfg_valid) out_data <= new_word;
            end else if (!out_valid) begin
                if (i_cfg_valid) begin
                    out_data  <= new_word;
                    out_valid <= 1'b1;
                end
            end else if (fire) begin
                if (pend_valid) begin
                    out_data <= pend_data;
                    if (i_cfg_valid) pend_data  <= new_word;
                    else             pend_valid <= 1'b0;
                end else if (i_cfg_valid) begin
                    out_data <= new_word;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (i_cfg_valid) begin
                // Stalled: the newest word replaces whatever was pending.
                pend_data  <= new_word;
                pend_valid <= 1'b1;
                if (pend_valid) begin
                    o_overrun <= 1'b1;
                    if (o_overrun_cnt != '1) o_overrun_cnt <= o_overrun_cnt + OVR_CNT_W'(1);
                end
            end
        end
    end

    assign m_axis_config_tdata  = out_data;
    assign m_axis_config_tvalid = out_valid;
    assign o_busy               = out_valid | pend_valid;

endmodule

// File: tb/tb_dds_cfg_bridge.sv
// Self-checking bench for dds_cfg_bridge: a word-queue scoreboard predicts
// every beat, pulse and the overrun count; per-feature tasks add targeted checks.
module tb_dds_cfg_bridge;

    localparam int OVR_W = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_valid = 1'b0;
    logic [15:0] pinc = '0;
    logic [15:0] poff = '0;
    logic        flush = 1'b0;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready = 1'b0;
    logic        cfg_done;
    logic        overrun;
    logic [OVR_W-1:0] overrun_cnt;
    logic        busy;

    dds_cfg_bridge #(
        .PINC_W(16), .POFF_W(16), .TDATA_W(32), .OVR_CNT_W(OVR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_cfg_valid(cfg_valid),
        .i_pinc(pinc),
        .i_poff(poff),
        .i_flush(flush),
        .m_axis_config_tdata(tdata),
        .m_axis_config_tvalid(tvalid),
        .m_axis_config_tready(tready),
        .o_cfg_done(cfg_done),
        .o_overrun(overrun),
        .o_overrun_cnt(overrun_cnt),
        .o_busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Scoreboard: words the DUT still owes the DDS, oldest first (at most two).
    logic [31:0]      sb_q[$];
    logic             exp_done = 1'b0;
    logic             exp_ovr  = 1'b0;
    logic [OVR_W-1:0] exp_cnt  = '0;
    int               model_ovr_pulses = 0;
    int               seen_ovr_pulses  = 0;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock of stimulus: compare outputs at the negedge against the
    // scoreboard, drive the new inputs, then advance the queue model.
    task automatic step(input logic v, input logic [15:0] p, input logic [15:0] o,
                        input logic rdy, input logic fl);
        logic        fire;
        logic [31:0] w;
        @(negedge clk);
        checks++;
        if (tvalid !== (sb_q.size() > 0)) begin
            errors++;
            $display("FAIL sb_tvalid: got %0b expected %0b at %0t", tvalid, sb_q.size() > 0, $time);
        end
        if (sb_q.size() > 0) begin
            checks++;
            if (tdata !== sb_q[0]) begin
                errors++;
                $display("FAIL sb_tdata: got %h expected %h at %0t", tdata, sb_q[0], $time);
            end
        end
        checks++;
        if (busy !== (sb_q.size() > 0)) begin
            errors++;
            $display("FAIL sb_busy: got %0b expected %0b at %0t", busy, sb_q.size() > 0, $time);
        end
        checks++;
        if (cfg_done !== exp_done) begin
            errors++;
            $display("FAIL sb_cfg_done: got %0b expected %0b at %0t", cfg_done, exp_done, $time);
        end
        checks++;
        if (overrun !== exp_ovr) begin
            errors++;
            $display("FAIL sb_overrun: got %0b expected %0b at %0t", overrun, exp_ovr, $time);
        end
        checks++;
        if (overrun_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL sb_overrun_cnt: got %0d expected %0d at %0t", overrun_cnt, exp_cnt, $time);
        end
        if (overrun === 1'b1) seen_ovr_pulses++;

        cfg_valid = v;
        pinc      = p;
        poff      = o;
        tready    = rdy;
        flush     = fl;

        w        = {16'h0000, o, p};
        fire     = (sb_q.size() > 0) && rdy;
        exp_done = fire;
        exp_ovr  = 1'b0;
        if (fl) begin
            sb_q.delete();
            if (v) sb_q.push_back(w);
        end else begin
            if (fire) void'(sb_q.pop_front());
            if (v) begin
                if (!fire && sb_q.size() == 2) begin
                    sb_q[1] = w;
                    exp_ovr = 1'b1;
                    model_ovr_pulses++;
                    if (exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
                end else begin
                    sb_q.push_back(w);
                end
            end
        end
    endtask

    task automatic idle(input logic rdy, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 16'h0, rdy, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        cfg_valid = 1'b0; flush = 1'b0; tready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        exp_done = 1'b0;
        exp_ovr  = 1'b0;
        exp_cnt  = '0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (tvalid !== 1'b0 || tdata !== 32'h0 || busy !== 1'b0 || cfg_done !== 1'b0 ||
            overrun !== 1'b0 || overrun_cnt !== '0) begin
            errors++;
            $display("FAIL reset_state: tvalid=%b tdata=%h busy=%b done=%b ovr=%b cnt=%0d expected all zero",
                     tvalid, tdata, busy, cfg_done, overrun, overrun_cnt);
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        step(1'b1, 16'h0100, 16'h0000, 1'b1, 1'b0);
        step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        checks++;
        if (tvalid !== 1'b1 || tdata !== 32'h0000_0100) begin
            errors++;
            $display("FAIL single_beat: tvalid=%b tdata=%h expected 1 / 00000100", tvalid, tdata);
        end
        idle(1'b1, 2);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        step(1'b1, 16'h0100, 16'h0000, 1'b0, 1'b0);
        step(1'b1, 16'h0200, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
            checks++;
            if (tdata !== 32'h0000_0100 || tvalid !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold: tvalid=%b tdata=%h expected 1 / 00000100", tvalid, tdata);
            end
        end
        idle(1'b1, 4);
    endtask

    task automatic test_overrun();
        do_reset();
        step(1'b1, 16'h0100, 16'h0, 1'b0, 1'b0);
        step(1'b1, 16'h0200, 16'h0, 1'b0, 1'b0);
        step(1'b1, 16'h0300, 16'h0, 1'b0, 1'b0);
        step(1'b1, 16'h0400, 16'h0, 1'b0, 1'b0);
        idle(1'b0, 2);
        checks++;
        if (overrun_cnt !== 2'd2) begin
            errors++;
            $display("FAIL ovr_count: got %0d expected 2", overrun_cnt);
        end
        idle(1'b1, 4);
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 16'(16'h1000 + i), 16'h0, 1'b0, 1'b0);
        idle(1'b0, 1);
        checks++;
        if (overrun_cnt !== 2'd3) begin
            errors++;
            $display("FAIL ovr_saturate: got %0d expected 3", overrun_cnt);
        end
        idle(1'b1, 4);
    endtask

    task automatic test_flush();
        do_reset();
        step(1'b1, 16'h0100, 16'h0, 1'b0, 1'b0);
        step(1'b1, 16'h0200, 16'h0, 1'b0, 1'b0);
        step(1'b1, 16'h0500, 16'h0, 1'b0, 1'b1);
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        checks++;
        if (tvalid !== 1'b1 || tdata !== 32'h0000_0500 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL flush_load: tvalid=%b tdata=%h ovr=%b expected 1 / 00000500 / 0",
                     tvalid, tdata, overrun);
        end
        idle(1'b1, 3);
    endtask

    task automatic test_async_reset();
        do_reset();
        step(1'b1, 16'h0700, 16'h0011, 1'b0, 1'b0);
        step(1'b1, 16'h0800, 16'h0022, 1'b0, 1'b0);
        step(1'b1, 16'h0900, 16'h0033, 1'b0, 1'b0);
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (tvalid !== 1'b0 || busy !== 1'b0 || overrun_cnt !== '0) begin
            errors++;
            $display("FAIL async_reset: tvalid=%b busy=%b cnt=%0d expected 0 / 0 / 0",
                     tvalid, busy, overrun_cnt);
        end
        @(negedge clk);
        cfg_valid = 1'b0;
        rst = 1'b0;
        sb_q.delete();
        exp_done = 1'b0;
        exp_ovr  = 1'b0;
        exp_cnt  = '0;
        step(1'b1, 16'h0A00, 16'h0001, 1'b1, 1'b0);
        idle(1'b1, 3);
    endtask

    task automatic test_random();
        int gap;
        do_reset();
        model_ovr_pulses = 0;
        seen_ovr_pulses  = 0;
        gap = 1;
        for (int i = 0; i < 400; i++) begin
            gap--;
            if (gap == 0) begin
                gap = $urandom_range(1, 5);
                step(1'b1, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 2) == 0), 1'b0);
            end else begin
                step(1'b0, 16'h0, 16'h0, 1'($urandom_range(0, 2) == 0), 1'b0);
            end
        end
        idle(1'b1, 5);
        checks++;
        if (seen_ovr_pulses !== model_ovr_pulses) begin
            errors++;
            $display("FAIL rand_ovr_pulses: got %0d expected %0d", seen_ovr_pulses, model_ovr_pulses);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rand_drain: busy=%b expected 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_overrun();
        test_saturate();
        test_flush();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
